// File: rtl/deserializador.sv
// deserializador: serial-to-parallel converter feeding an N-bit data register.
// Bits are shifted in on qualified rising edges. A finished word is held on a
// valid/ready output until accepted. A sticky overrun flag is raised when a
// finished word has to be dropped because the previous one is still pending.
//
// state | meaning
// IDLE  | no partial word; bit_count = 0
// RECV  | partial word in progress; bit_count = bits received so far
module deserializador #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 serial_in,
    input  logic                 bit_valid,
    input  logic                 clear,
    input  logic                 word_ready,
    output logic [N-1:0]         word_out,
    output logic                 word_valid,
    output logic                 busy,
    output logic [$clog2(N)-1:0] bit_count,
    output logic                 overrun
);

    localparam int CW = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t         state;
    logic [N-1:0]   shift_reg;
    logic [N-1:0]   shift_next;
    logic           last_bit;
    logic           accept;

    // Next shift-register value, including the bit currently on serial_in,
    // so the completing edge can load the full word straight into word_out.
    always_comb begin
        shift_next = '0;
        if (MSB_FIRST) begin
            shift_next = {shift_reg[N-2:0], serial_in};
        end else begin
            shift_next = {serial_in, shift_reg[N-1:1]};
        end
    end

    assign last_bit = (bit_count == CW'(N - 1));
    assign accept   = word_valid && word_ready;

    // Receive FSM with registered outputs; hand-off and overrun are resolved on
    // the completing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            busy       <= 1'b0;
            bit_count  <= '0;
            overrun    <= 1'b0;
        end else begin
            // Acceptance is independent of the receive side; a load on the
            // same edge below overrides this and keeps word_valid high.
            if (accept) begin
                word_valid <= 1'b0;
            end

            if (clear) begin
                state     <= IDLE;
                busy      <= 1'b0;
                bit_count <= '0;
                shift_reg <= '0;
                overrun   <= 1'b0;
            end else if (bit_valid) begin
                shift_reg <= shift_next;
                case (state)
                    IDLE: begin
                        // N >= 2, so the first bit never completes a word.
                        state     <= RECV;
                        busy      <= 1'b1;
                        bit_count <= CW'(1);
                    end
                    RECV: begin
                        if (last_bit) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            bit_count <= '0;
                            if (!word_valid || word_ready) begin
                                word_out   <= shift_next;
                                word_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            bit_count <= bit_count + CW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_deserializador.sv
// Bench for deserializador: two instances (MSB-first and LSB-first) share one
// serial stream. Expected words are queued at stimulus time and popped by
// per-instance monitors whenever a word is accepted (word_valid && word_ready).
module tb_deserializador;

    logic       clk;
    logic       rst_n;
    logic       serial_in;
    logic       bit_valid;
    logic       clear;
    logic       word_ready;

    logic [7:0] word_out_m;
    logic       word_valid_m;
    logic       busy_m;
    logic [2:0] bit_count_m;
    logic       overrun_m;

    logic [7:0] word_out_l;
    logic       word_valid_l;
    logic       busy_l;
    logic [2:0] bit_count_l;
    logic       overrun_l;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_m[$];
    logic [7:0] exp_l[$];

    deserializador #(.N(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .serial_in  (serial_in),
        .bit_valid  (bit_valid),
        .clear      (clear),
        .word_ready (word_ready),
        .word_out   (word_out_m),
        .word_valid (word_valid_m),
        .busy       (busy_m),
        .bit_count  (bit_count_m),
        .overrun    (overrun_m)
    );

    deserializador #(.N(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .serial_in  (serial_in),
        .bit_valid  (bit_valid),
        .clear      (clear),
        .word_ready (word_ready),
        .word_out   (word_out_l),
        .word_valid (word_valid_l),
        .busy       (busy_l),
        .bit_count  (bit_count_l),
        .overrun    (overrun_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Monitors: compare each accepted word against the head of its queue.
    always @(negedge clk) begin
        if (rst_n && word_valid_m && word_ready) begin
            if (exp_m.size() == 0) begin
                chk("msb_unexpected_word", word_out_m, 32'hFFFF_FFFF);
            end else begin
                chk("msb_word", word_out_m, exp_m.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && word_valid_l && word_ready) begin
            if (exp_l.size() == 0) begin
                chk("lsb_unexpected_word", word_out_l, 32'hFFFF_FFFF);
            end else begin
                chk("lsb_word", word_out_l, exp_l.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        serial_in = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
        repeat (gap) tick();
    endtask

    // Sends w MSB-of-w first. The LSB-first instance therefore assembles rev8(w).
    task automatic send_word(input logic [7:0] w, input int gap, input bit push, input bit rdy_last);
        if (push) begin
            exp_m.push_back(w);
            exp_l.push_back(rev8(w));
        end
        for (int i = 7; i >= 0; i--) begin
            if (i == 0 && rdy_last) word_ready = 1'b1;
            send_bit(w[i], (i == 0) ? 0 : gap);
        end
    endtask

    task automatic chk_word(input string name, input logic [7:0] w);
        chk({name, "_msb"}, word_out_m, w);
        chk({name, "_lsb"}, word_out_l, rev8(w));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        clk        = 1'b0;
        rst_n      = 1'b0;
        serial_in  = 1'b0;
        bit_valid  = 1'b0;
        clear      = 1'b0;
        word_ready = 1'b0;
        tick();
        chk("rst_word_out", word_out_m, 8'h00);
        chk("rst_word_valid", word_valid_m, 1'b0);
        chk("rst_busy", busy_m, 1'b0);
        chk("rst_bit_count", bit_count_m, 3'd0);
        chk("rst_overrun", overrun_m, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1/2: back-to-back bits, word_ready=1
        word_ready = 1'b1;
        send_word(8'hB2, 0, 1'b1, 1'b0);
        chk_word("t1_word", 8'hB2);
        chk("t1_valid", word_valid_m, 1'b1);
        chk("t1_busy", busy_m, 1'b0);
        chk("t1_bit_count", bit_count_m, 3'd0);
        chk("t1_lsb_valid", word_valid_l, 1'b1);
        tick();
        chk("t1_valid_one_cycle", word_valid_m, 1'b0);

        // 2: same word with 3 idle cycles between bits
        send_word(8'hB2, 3, 1'b1, 1'b0);
        chk_word("t2_gap_word", 8'hB2);
        chk("t2_valid", word_valid_l, 1'b1);
        tick();
        chk("t2_valid_drop", word_valid_l, 1'b0);

        // 3: overrun with word_ready=0
        word_ready = 1'b0;
        send_word(8'hB2, 0, 1'b1, 1'b0);
        send_word(8'h0F, 0, 1'b0, 1'b0);
        chk_word("t3_held", 8'hB2);
        chk("t3_overrun_m", overrun_m, 1'b1);
        chk("t3_overrun_l", overrun_l, 1'b1);
        chk("t3_valid", word_valid_m, 1'b1);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        chk("t3_valid_after_ready", word_valid_m, 1'b0);
        chk("t3_overrun_sticky", overrun_m, 1'b1);
        tick();
        chk("t3_overrun_still", overrun_l, 1'b1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t3_overrun_cleared", overrun_m, 1'b0);
        chk("t3_clear_keeps_word", word_out_m, 8'hB2);

        // 4: completion coinciding with acceptance of the pending word
        send_word(8'hB2, 0, 1'b1, 1'b0);
        chk("t4_pending", word_valid_m, 1'b1);
        send_word(8'hA5, 0, 1'b1, 1'b1);
        chk_word("t4_word", 8'hA5);
        chk("t4_valid", word_valid_m, 1'b1);
        chk("t4_overrun", overrun_m, 1'b0);
        tick();
        chk("t4_accepted", word_valid_m, 1'b0);

        // 5: clear together with a bit aborts the partial word
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        chk("t5_bit_count_3", bit_count_m, 3'd3);
        chk("t5_busy", busy_l, 1'b1);
        serial_in = 1'b0;
        bit_valid = 1'b1;
        clear     = 1'b1;
        tick();
        bit_valid = 1'b0;
        clear     = 1'b0;
        chk("t5_bit_count_clear", bit_count_m, 3'd0);
        chk("t5_busy_clear", busy_m, 1'b0);
        chk("t5_overrun", overrun_m, 1'b0);
        send_word(8'h3C, 0, 1'b1, 1'b0);
        chk_word("t5_word", 8'h3C);
        chk("t5_overrun_after", overrun_l, 1'b0);
        tick();

        // 6: async reset mid-word
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        chk("t6_bit_count_5", bit_count_l, 3'd5);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_word_out", word_out_m, 8'h00);
        chk("t6_rst_word_out_l", word_out_l, 8'h00);
        chk("t6_rst_busy", busy_m, 1'b0);
        chk("t6_rst_bit_count", bit_count_m, 3'd0);
        chk("t6_rst_valid", word_valid_m, 1'b0);
        chk("t6_rst_overrun", overrun_m, 1'b0);
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        send_word(8'hFF, 0, 1'b1, 1'b0);
        chk_word("t6_word", 8'hFF);
        chk("t6_valid", word_valid_m, 1'b1);
        tick();
        tick();

        chk("queue_msb_empty", exp_m.size(), 0);
        chk("queue_lsb_empty", exp_l.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
